// File: rtl/fft8_input_feeder.sv
// Input reorder buffer for an 8-point radix-2 DIT FFT: loads one frame in bit-reversed order,
// then presents it as four first-stage butterfly pairs with a unity twiddle.
module fft8_input_feeder #(
  parameter int unsigned N_LOG2 = 3,   // only 3 is supported
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int unsigned DEPTH = 1 << N_LOG2;
  localparam int unsigned AW    = N_LOG2;
  localparam int unsigned PW    = N_LOG2 - 1;
  localparam int unsigned NPAIR = DEPTH / 2;
  localparam int unsigned HW    = DATA_W / 2;

  // Q1.15 unity twiddle: real = max positive, imag = 0
  localparam logic [DATA_W-1:0] W_ONE = {1'b0, {(HW - 1){1'b1}}, {HW{1'b0}}};

  localparam logic [AW-1:0] LOAD_LAST = AW'(DEPTH - 1);
  localparam logic [PW-1:0] PAIR_LAST = PW'(NPAIR - 1);

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t            state;
  logic [AW-1:0]     load_cnt;
  logic [PW-1:0]     pair_cnt;
  logic [PW-1:0]     next_pair;
  logic              accept;
  logic [DATA_W-1:0] sample_mem [DEPTH];

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] k);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(AW); i++) begin
      r[i] = k[int'(AW) - 1 - i];
    end
    return r;
  endfunction

  // in_ready is only ever high in LOAD, so accept implies LOAD
  assign accept    = in_valid && in_ready;
  assign next_pair = pair_cnt + PW'(1);

  // Sample storage; contents are don't-care until a full frame has been written
  always_ff @(posedge clk) begin
    if (accept) begin
      sample_mem[bitrev(load_cnt)] <= in_data;
    end
  end

  // Frame sequencer with registered handshake and operand outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      load_cnt  <= '0;
      pair_cnt  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_w     <= '0;
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (load_cnt == LOAD_LAST) begin
              // The final sample lands at the last address, never in pair 0
              state     <= EMIT;
              load_cnt  <= '0;
              pair_cnt  <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_last  <= (NPAIR == 1);
              out_a     <= sample_mem[AW'(0)];
              out_b     <= sample_mem[AW'(1)];
              out_w     <= W_ONE;
            end else begin
              load_cnt <= load_cnt + AW'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (pair_cnt == PAIR_LAST) begin
              state     <= LOAD;
              pair_cnt  <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              pair_cnt <= next_pair;
              out_a    <= sample_mem[{next_pair, 1'b0}];
              out_b    <= sample_mem[{next_pair, 1'b1}];
              out_last <= (next_pair == PAIR_LAST);
            end
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
